// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared types and constants for the 2-way write-through data cache.
//   cache_state_t : controller states (IDLE, RD_MISS, WR_THRU)
//   tag_width()   : tag width for a given number of set-index bits
//   line_t        : one cache line {valid, tag, data}. The tag field is sized
//                   for the smallest legal set count (widest tag). Narrower
//                   tags are zero-extended into it, so the upper bits are
//                   constant and drop out in synthesis.
// -----------------------------------------------------------------------------
package cache_pkg;

   localparam int CACHE_ADDR_W       = 32;
   localparam int CACHE_DATA_W       = 32;
   localparam int CACHE_SET_BITS_MIN = 1;

   function automatic int tag_width(input int set_bits);
      return CACHE_ADDR_W - set_bits - 2;
   endfunction

   localparam int CACHE_TAG_W_MAX = tag_width(CACHE_SET_BITS_MIN);

   typedef enum logic [1:0] {
      IDLE,
      RD_MISS,
      WR_THRU
   } cache_state_t;

   typedef struct packed {
      logic                       valid;
      logic [CACHE_TAG_W_MAX-1:0] tag;
      logic [CACHE_DATA_W-1:0]    data;
   } line_t;

endpackage

// File: rtl/cache_way.sv
// -----------------------------------------------------------------------------
// cache_way
// One way of the cache. It holds a valid/tag/data entry per set.
// Ports:
//   clk, rst  : clock and synchronous active-high reset. Reset clears only
//               the valid bits.
//   rd_index  : set to read. The read is combinational.
//   rd_line   : line at rd_index. The tag is zero-extended into line_t.
//   wr_en     : write strobe. Writes the line at wr_index on the rising edge
//               and marks it valid.
//   wr_index, wr_tag, wr_data : write port address and contents
// -----------------------------------------------------------------------------
module cache_way
   import cache_pkg::*;
#(
   parameter int SET_BITS = 3,
   parameter int TAG_W    = tag_width(SET_BITS)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SET_BITS-1:0]     rd_index,
   output line_t                   rd_line,
   input  logic                    wr_en,
   input  logic [SET_BITS-1:0]     wr_index,
   input  logic [TAG_W-1:0]        wr_tag,
   input  logic [CACHE_DATA_W-1:0] wr_data
);

   localparam int SETS = 1 << SET_BITS;

   logic [SETS-1:0]         valid_q;
   logic [SETS-1:0]         valid_d;
   logic [TAG_W-1:0]        tag_q  [SETS];
   logic [CACHE_DATA_W-1:0] data_q [SETS];

   always_comb begin
      valid_d = valid_q;
      if (wr_en) begin
         valid_d[wr_index] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Tag and data need no reset. A line is never used until its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag_q[wr_index]  <= wr_tag;
         data_q[wr_index] <= wr_data;
      end
   end

   always_comb begin
      rd_line       = '0;
      rd_line.valid = valid_q[rd_index];
      rd_line.tag   = CACHE_TAG_W_MAX'(tag_q[rd_index]);
      rd_line.data  = data_q[rd_index];
   end

endmodule

// File: rtl/cache_2way_wt.sv
// -----------------------------------------------------------------------------
// cache_2way_wt
// 2-way set-associative data cache. It is write-through, does not allocate on
// writes, and holds one 32-bit word per line. Load hits are answered
// combinationally. Load misses and all stores stall the pipeline while a
// mem_req/mem_valid transaction runs.
// Ports:
//   clk, rst         : clock and synchronous active-high reset
//   cpu_req, cpu_we  : access request and store flag from the memory stage
//   cpu_addr         : byte address. Bits [1:0] are ignored.
//   cpu_wdata        : store data
//   cpu_rdata        : load data. Zero when no load completes this cycle.
//   cpu_stall        : pipeline freeze
//   mem_req, mem_we  : memory request and write flag. Held until mem_valid.
//   mem_addr         : word-aligned memory address
//   mem_wdata        : memory write data
//   mem_rdata        : memory read data
//   mem_valid        : one-cycle completion strobe from memory
// Optional feature (macro CACHE_STATS_EN): adds the stat_hits and
// stat_misses counters. They count IDLE load hits and IDLE load misses,
// saturate at all-ones, and clear on reset.
// -----------------------------------------------------------------------------
module cache_2way_wt
   import cache_pkg::*;
#(
   parameter int SET_BITS   = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  cpu_stall,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_valid
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0]           stat_hits,
   output logic [31:0]           stat_misses
`endif
);

   localparam int TAG_W = tag_width(SET_BITS);
   localparam int SETS  = 1 << SET_BITS;

   cache_state_t          state_q, state_d;
   logic [ADDR_WIDTH-3:0] addr_q, addr_d;     // word address of the pending access
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  mem_req_q, mem_req_d;
   logic                  mem_we_q, mem_we_d;
   logic [SETS-1:0]       lru_q, lru_d;       // way to replace next in each set

   logic [SET_BITS-1:0]   acc_index;
   logic [TAG_W-1:0]      acc_tag;
   line_t                 way_line [2];
   logic                  hit0, hit1, hit_any;
   logic                  victim;
   logic [1:0]            way_wr_en;
   logic [DATA_WIDTH-1:0] way_wr_data;
   logic                  ld_hit, ld_miss;
   logic                  unused_addr_bits;

   assign unused_addr_bits = &{1'b0, cpu_addr[1:0]};

   // In IDLE, look up the live CPU address. During a miss, use the registered
   // address so the refill goes to the set and tag that missed.
   always_comb begin
      if (state_q == IDLE) begin
         acc_index = cpu_addr[SET_BITS+1:2];
         acc_tag   = cpu_addr[ADDR_WIDTH-1:SET_BITS+2];
      end else begin
         acc_index = addr_q[SET_BITS-1:0];
         acc_tag   = addr_q[ADDR_WIDTH-3:SET_BITS];
      end
   end

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_way
      cache_way #(
         .SET_BITS (SET_BITS),
         .TAG_W    (TAG_W)
      ) u_way (
         .clk      (clk),
         .rst      (rst),
         .rd_index (acc_index),
         .rd_line  (way_line[gi]),
         .wr_en    (way_wr_en[gi] && !rst),
         .wr_index (acc_index),
         .wr_tag   (acc_tag),
         .wr_data  (way_wr_data)
      );
   end

   assign hit0    = way_line[0].valid && (way_line[0].tag == CACHE_TAG_W_MAX'(acc_tag));
   assign hit1    = way_line[1].valid && (way_line[1].tag == CACHE_TAG_W_MAX'(acc_tag));
   assign hit_any = hit0 || hit1;

   // Pick an empty way first, way0 before way1. Otherwise pick the LRU way.
   always_comb begin
      if (!way_line[0].valid) begin
         victim = 1'b0;
      end else if (!way_line[1].valid) begin
         victim = 1'b1;
      end else begin
         victim = lru_q[acc_index];
      end
   end

   assign ld_hit  = !rst && (state_q == IDLE) && cpu_req && !cpu_we && hit_any;
   assign ld_miss = !rst && (state_q == IDLE) && cpu_req && !cpu_we && !hit_any;

   // Next-state logic, register updates and way writes
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      lru_d       = lru_q;
      way_wr_en   = 2'b00;
      way_wr_data = cpu_wdata;
      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               addr_d = cpu_addr[ADDR_WIDTH-1:2];
               if (cpu_we) begin
                  wdata_d   = cpu_wdata;
                  mem_req_d = 1'b1;
                  mem_we_d  = 1'b1;
                  state_d   = WR_THRU;
                  if (hit_any) begin
                     // Write-through also updates the cached copy on a hit.
                     way_wr_en           = {hit1, hit0};
                     lru_d[acc_index]    = hit0;
                  end
               end else if (hit_any) begin
                  // A hit in way0 makes way1 the next victim, and vice versa.
                  lru_d[acc_index] = hit0;
               end else begin
                  mem_req_d = 1'b1;
                  mem_we_d  = 1'b0;
                  state_d   = RD_MISS;
               end
            end
         end
         RD_MISS: begin
            if (mem_valid) begin
               way_wr_en[victim] = 1'b1;
               way_wr_data       = mem_rdata;
               lru_d[acc_index]  = ~victim;
               mem_req_d         = 1'b0;
               state_d           = IDLE;
            end
         end
         WR_THRU: begin
            if (mem_valid) begin
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         mem_req_q <= 1'b0;
         mem_we_q  <= 1'b0;
         lru_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         mem_req_q <= mem_req_d;
         mem_we_q  <= mem_we_d;
         lru_q     <= lru_d;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = {addr_q, 2'b00};
   assign mem_wdata = wdata_q;

   // CPU-facing outputs. Stall drops in the mem_valid cycle so the pipeline
   // captures the data and moves on in the same cycle.
   always_comb begin
      cpu_stall = 1'b0;
      cpu_rdata = '0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (cpu_req) begin
                  if (cpu_we || !hit_any) begin
                     cpu_stall = 1'b1;
                  end else begin
                     cpu_rdata = hit0 ? way_line[0].data : way_line[1].data;
                  end
               end
            end
            RD_MISS: begin
               cpu_stall = !mem_valid;
               if (mem_valid) begin
                  cpu_rdata = mem_rdata;
               end
            end
            WR_THRU: cpu_stall = !mem_valid;
            default: cpu_stall = 1'b0;
         endcase
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] stat_hits_q, stat_hits_d;
   logic [31:0] stat_misses_q, stat_misses_d;

   always_comb begin
      stat_hits_d   = stat_hits_q;
      stat_misses_d = stat_misses_q;
      if (ld_hit && (stat_hits_q != 32'hFFFF_FFFF)) begin
         stat_hits_d = stat_hits_q + 32'd1;
      end
      if (ld_miss && (stat_misses_q != 32'hFFFF_FFFF)) begin
         stat_misses_d = stat_misses_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_hits_q   <= '0;
         stat_misses_q <= '0;
      end else begin
         stat_hits_q   <= stat_hits_d;
         stat_misses_q <= stat_misses_d;
      end
   end

   assign stat_hits   = stat_hits_q;
   assign stat_misses = stat_misses_q;
`else
   logic unused_stats;
   assign unused_stats = &{1'b0, ld_hit, ld_miss};
`endif

   // A line is never filled while it is already present, so two ways can
   // never hold the same tag in one set.
   a_one_hit : assert property (@(posedge clk) disable iff (rst) !(hit0 && hit1));

endmodule

// File: tb/tb_cache_2way_wt.sv
module tb_cache_2way_wt;

   localparam int SET_BITS = 3;
   localparam int SETS     = 1 << SET_BITS;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_stall, mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_valid;
`ifdef CACHE_STATS_EN
   logic [31:0] stat_hits, stat_misses;
`endif

   cache_2way_wt #(.SET_BITS(SET_BITS), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_stall (cpu_stall),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid)
`ifdef CACHE_STATS_EN
      ,
      .stat_hits   (stat_hits),
      .stat_misses (stat_misses)
`endif
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model. Each set is a recency list of up to two word
   // addresses, most recent first. Memory is a sparse word array.
   logic [29:0] slot_m [SETS][2];
   int          cnt_m  [SETS];
   logic [31:0] mem_m  [logic [29:0]];
   int          hits_m, misses_m;

   function automatic logic [31:0] mem_rd(input logic [29:0] w);
      if (mem_m.exists(w)) return mem_m[w];
      return {2'b10, w};
   endfunction

   function automatic bit cached(input logic [29:0] w);
      int s = int'(w[SET_BITS-1:0]);
      for (int i = 0; i < cnt_m[s]; i++) begin
         if (slot_m[s][i] == w) return 1'b1;
      end
      return 1'b0;
   endfunction

   // Make w the most recent entry of its set and drop the oldest if needed.
   function automatic void touch(input logic [29:0] w);
      int s = int'(w[SET_BITS-1:0]);
      if (cnt_m[s] > 0 && slot_m[s][0] == w) return;
      if (!cached(w) && cnt_m[s] < 2) cnt_m[s] = cnt_m[s] + 1;
      slot_m[s][1] = slot_m[s][0];
      slot_m[s][0] = w;
   endfunction

   function automatic void model_reset();
      for (int s = 0; s < SETS; s++) cnt_m[s] = 0;
      hits_m   = 0;
      misses_m = 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One CPU access. The bench drives mem_valid in the access's 1+lat'th
   // cycle. Outputs are checked at every negedge until the model says the
   // access completes.
   task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int lat, output int stall_cycles, output logic [31:0] rdata_seen);
      logic [29:0] w        = addr[31:2];
      bit          hit      = cached(w);
      bit          need_mem = we || !hit;
      logic [31:0] exp_rd   = mem_rd(w);
      bit          done     = 1'b0;
      int          cyc      = 0;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      stall_cycles = 0;
      rdata_seen   = '0;
      while (!done) begin
         if (need_mem && cyc == 1 + lat) begin
            mem_valid = 1'b1;
            mem_rdata = we ? $urandom : exp_rd;
         end else begin
            mem_valid = 1'b0;
            mem_rdata = $urandom;
         end
         @(negedge clk);
         done = need_mem ? (cyc == 1 + lat) : (cyc == 0);
         chk("cpu_stall", 32'(cpu_stall), 32'(!done));
         chk("mem_req", 32'(mem_req), 32'(need_mem && cyc >= 1));
         if (need_mem && cyc >= 1) begin
            chk("mem_we", 32'(mem_we), 32'(we));
            chk("mem_addr", mem_addr, {w, 2'b00});
            if (we) chk("mem_wdata", mem_wdata, wdata);
         end
         if (done && !we) chk("cpu_rdata", cpu_rdata, exp_rd);
         if (cpu_stall) stall_cycles++;
         if (done) rdata_seen = cpu_rdata;
         @(posedge clk);
         #1;
         cyc++;
      end
      mem_valid = 1'b0;
      cpu_req   = 1'b0;
      if (!we) begin
         if (hit) hits_m++;
         else     misses_m++;
         touch(w);
      end else begin
         mem_m[w] = wdata;
         if (hit) touch(w);
      end
      $display("access we=%0d addr=%h lat=%0d model_hit=%0d stall=%0d rdata=%h",
               we, addr, lat, hit, stall_cycles, rdata_seen);
   endtask

   // Cycles with no request. A spurious mem_valid may be pulsed, and the
   // cache must ignore it.
   task automatic idle(input int n, input bit spurious);
      cpu_req   = 1'b0;
      cpu_we    = 1'($urandom);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      for (int i = 0; i < n; i++) begin
         mem_valid = spurious && ($urandom_range(0, 1) == 1);
         mem_rdata = $urandom;
         @(negedge clk);
         chk("idle_stall", 32'(cpu_stall), 32'd0);
         chk("idle_mem_req", 32'(mem_req), 32'd0);
         chk("idle_rdata", cpu_rdata, 32'd0);
         @(posedge clk);
         #1;
      end
      mem_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      cpu_req   = 1'b0;
      mem_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      int          sc;
      logic [31:0] rd;
      rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      mem_valid = 1'b0; mem_rdata = '0;
      mem_m[30'h10] = 32'hDEADBEEF;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_stall", 32'(cpu_stall), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      @(posedge clk); #1;

      // First fill, then a hit
      access(1'b0, 32'h40, 32'h0, 3, sc, rd);
      chk("t1_miss_stall", 32'(sc), 32'd4);
      chk("t1_miss_data", rd, 32'hDEADBEEF);
      access(1'b0, 32'h40, 32'h0, 0, sc, rd);
      chk("t1_hit_stall", 32'(sc), 32'd0);
      chk("t1_hit_data", rd, 32'hDEADBEEF);

      // LRU eviction within set 0
      access(1'b0, 32'h140, 32'h0, 1, sc, rd);
      chk("t2_140_miss", 32'(sc), 32'd2);
      access(1'b0, 32'h240, 32'h0, 1, sc, rd);
      chk("t2_240_miss", 32'(sc), 32'd2);
      access(1'b0, 32'h140, 32'h0, 0, sc, rd);
      chk("t2_140_hit", 32'(sc), 32'd0);
      access(1'b0, 32'h240, 32'h0, 0, sc, rd);
      chk("t2_240_hit", 32'(sc), 32'd0);
      access(1'b0, 32'h40, 32'h0, 2, sc, rd);
      chk("t2_40_evicted", 32'(sc), 32'd3);
      access(1'b0, 32'h240, 32'h0, 0, sc, rd);
      chk("t2_240_still_hit", 32'(sc), 32'd0);
      access(1'b0, 32'h140, 32'h0, 0, sc, rd);
      chk("t2_140_now_evicted", 32'(sc), 32'd1);

      // Store hit updates the cached word and memory
      access(1'b0, 32'h80, 32'h0, 1, sc, rd);
      access(1'b1, 32'h80, 32'h12345678, 2, sc, rd);
      chk("t3_store_stall", 32'(sc), 32'd3);
      access(1'b0, 32'h80, 32'h0, 0, sc, rd);
      chk("t3_hit_stall", 32'(sc), 32'd0);
      chk("t3_hit_data", rd, 32'h12345678);

      // Store miss does not allocate a line
      access(1'b1, 32'h300, 32'hCAFEF00D, 0, sc, rd);
      chk("t4_store_stall", 32'(sc), 32'd1);
      access(1'b0, 32'h300, 32'h0, 1, sc, rd);
      chk("t4_load_miss", 32'(sc), 32'd2);
      chk("t4_load_data", rd, 32'hCAFEF00D);

      // Reset during a miss. The late mem_valid must be ignored.
      idle(2, 1'b1);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h1C0;
      @(negedge clk);
      chk("t5_req_stall", 32'(cpu_stall), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_rdmiss_req", 32'(mem_req), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0; mem_valid = 1'b1; mem_rdata = 32'h55555555;
      model_reset();
      @(negedge clk);
      chk("t5_post_rst_stall", 32'(cpu_stall), 32'd0);
      chk("t5_post_rst_req", 32'(mem_req), 32'd0);
      chk("t5_post_rst_rdata", cpu_rdata, 32'd0);
      @(posedge clk); #1;
      mem_valid = 1'b0;
      access(1'b0, 32'h1C0, 32'h0, 1, sc, rd);
      chk("t5_reload_miss", 32'(sc), 32'd2);
      access(1'b0, 32'h40, 32'h0, 0, sc, rd);
      chk("t5_invalidated", 32'(sc), 32'd1);

`ifdef CACHE_STATS_EN
      do_reset();
      access(1'b0, 32'h4, 32'h0, 0, sc, rd);
      access(1'b0, 32'h4, 32'h0, 0, sc, rd);
      access(1'b0, 32'h4, 32'h0, 0, sc, rd);
      access(1'b0, 32'h8, 32'h0, 1, sc, rd);
      access(1'b0, 32'h8, 32'h0, 0, sc, rd);
      access(1'b0, 32'hC, 32'h0, 0, sc, rd);
      access(1'b0, 32'hC, 32'h0, 0, sc, rd);
      access(1'b0, 32'h4, 32'h0, 0, sc, rd);
      @(negedge clk);
      chk("stat_misses", stat_misses, 32'd3);
      chk("stat_hits", stat_hits, 32'd5);
      @(posedge clk); #1;
      do_reset();
      @(negedge clk);
      chk("stat_misses_rst", stat_misses, 32'd0);
      chk("stat_hits_rst", stat_hits, 32'd0);
      @(posedge clk); #1;
`endif

      // Randomized traffic over a small address range, so sets conflict often
      for (int t = 0; t < 400; t++) begin
         logic        we;
         logic [29:0] w;
         logic [31:0] a;
         we = ($urandom_range(0, 2) == 0);
         w  = 30'($urandom_range(0, 31));
         a  = {w, 2'b00} | 32'($urandom_range(0, 3));
         access(we, a, $urandom, int'($urandom_range(0, 3)), sc, rd);
         if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), 1'b1);
      end

`ifdef CACHE_STATS_EN
      @(negedge clk);
      chk("stat_hits_rand", stat_hits, 32'(hits_m));
      chk("stat_misses_rand", stat_misses, 32'(misses_m));
      @(posedge clk); #1;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
